// File: rtl/count_pwm_gen.sv
// rtl/count_pwm_gen.sv - PWM generator driven by an external up-counter's Q bus
//
// Turns a free-running WIDTH-bit count into a registered PWM waveform, emits a
// one-cycle period pulse on each MAX->0 wrap, and double-buffers the duty value
// so that a write never changes the duty of a period already in progress.
//
// Optional feature macro: COUNT_PWM_STEP_CHECK_EN
//   When defined, a sticky step_err flags any count step other than hold or +1
//   while running. When undefined, step_err is tied low and err_clr is ignored.
//
// Ports:
//   clk           in   1        rising-edge clock
//   reset         in   1        synchronous, active-low reset
//   count_in      in   WIDTH    counter value Q
//   duty_wr       in   1        load duty_in into the pending duty register
//   duty_in       in   WIDTH+1  requested high-count per period (saturates to 2**WIDTH)
//   err_clr       in   1        clear sticky step_err
//   pwm_out       out  1        registered PWM output
//   period_pulse  out  1        one-cycle pulse per detected wrap
//   duty_active   out  WIDTH+1  duty currently in force
//   step_err      out  1        sticky illegal-step flag
module count_pwm_gen #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] count_in,
  input  logic             duty_wr,
  input  logic [WIDTH:0]   duty_in,
  input  logic             err_clr,
  output logic             pwm_out,
  output logic             period_pulse,
  output logic [WIDTH:0]   duty_active,
  output logic             step_err
);

  localparam logic [WIDTH-1:0] CNT_MAX   = '1;
  localparam logic [WIDTH:0]   DUTY_FULL = {1'b1, {WIDTH{1'b0}}};

  typedef enum logic {
    SYNC = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] cnt_q;
  logic             cnt_vld;     // cnt_q holds a real sample (not the reset value)
  logic [WIDTH:0]   pending;
  logic             pend_vld;
  logic [WIDTH:0]   duty_sat;
  logic [WIDTH:0]   duty_next;
  logic             wrap_evt;

  always_comb begin
    duty_sat   = (duty_in > DUTY_FULL) ? DUTY_FULL : duty_in;
    wrap_evt   = cnt_vld && (cnt_q == CNT_MAX) && (count_in == '0);
    next_state = wrap_evt ? RUN : state;
    // A write coinciding with the wrap bypasses the pending register.
    duty_next  = duty_active;
    if (wrap_evt) begin
      if (duty_wr)       duty_next = duty_sat;
      else if (pend_vld) duty_next = pending;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= SYNC;
      cnt_q        <= '0;
      cnt_vld      <= 1'b0;
      pending      <= '0;
      pend_vld     <= 1'b0;
      duty_active  <= '0;
      period_pulse <= 1'b0;
      pwm_out      <= 1'b0;
    end else begin
      state        <= next_state;
      cnt_q        <= count_in;
      cnt_vld      <= 1'b1;
      duty_active  <= duty_next;
      period_pulse <= wrap_evt;
      pwm_out      <= (next_state == RUN) && ({1'b0, count_in} < duty_next);
      if (wrap_evt) begin
        pend_vld <= 1'b0;
      end else if (duty_wr) begin
        pending  <= duty_sat;
        pend_vld <= 1'b1;
      end
    end
  end

`ifdef COUNT_PWM_STEP_CHECK_EN
  logic [WIDTH-1:0] cnt_inc;
  logic             bad_step;

  always_comb begin
    cnt_inc  = cnt_q + 1'b1;
    bad_step = (state == RUN) && (count_in != cnt_q) && (count_in != cnt_inc);
  end

  // Set has priority over clear so an error in the clearing cycle is not lost.
  always_ff @(posedge clk) begin
    if (!reset)        step_err <= 1'b0;
    else if (bad_step) step_err <= 1'b1;
    else if (err_clr)  step_err <= 1'b0;
  end
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign step_err       = 1'b0;
`endif

endmodule

// File: tb/tb_count_pwm_gen.sv
// tb/tb_count_pwm_gen.sv - self-checking bench for count_pwm_gen (WIDTH=3)
module tb_count_pwm_gen;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] count_in = '0;
  logic       duty_wr = 1'b0;
  logic [3:0] duty_in = '0;
  logic       err_clr = 1'b0;
  logic       pwm_out;
  logic       period_pulse;
  logic [3:0] duty_active;
  logic       step_err;

  int checks = 0;
  int errors = 0;

  count_pwm_gen #(.WIDTH(3)) dut (
    .clk(clk), .reset(reset), .count_in(count_in), .duty_wr(duty_wr),
    .duty_in(duty_in), .err_clr(err_clr), .pwm_out(pwm_out),
    .period_pulse(period_pulse), .duty_active(duty_active), .step_err(step_err)
  );

  always #5 clk = ~clk;

`ifdef COUNT_PWM_STEP_CHECK_EN
  localparam bit CHECK_ON = 1'b1;
`else
  localparam bit CHECK_ON = 1'b0;
`endif

  // Reference model: what the outputs must be after each clock.
  int  m_prev;      // previous sampled count, -1 when none since reset
  bit  m_run;       // a full wrap has been seen since reset
  int  m_pend;      // pending duty, -1 when nothing pending
  int  m_duty;
  bit  m_pwm, m_pulse, m_err;

  // Drive one cycle of inputs on the falling edge, advance the model, then
  // return just after the rising edge so callers can compare outputs.
  task automatic step(input bit r, input int c, input bit wr, input int d, input bit clr);
    bit wrap;
    bit bad;
    int sat;
    @(negedge clk);
    reset = r; count_in = 3'(c); duty_wr = wr; duty_in = 4'(d); err_clr = clr;
    if (!r) begin
      m_prev = -1; m_run = 0; m_pend = -1; m_duty = 0;
      m_pwm = 0; m_pulse = 0; m_err = 0;
    end else begin
      sat  = (d > 8) ? 8 : d;
      wrap = (m_prev == 7) && (c == 0);
      bad  = m_run && (c != m_prev) && (c != (m_prev + 1) % 8);
      if (wrap) begin
        if (wr)             m_duty = sat;
        else if (m_pend >= 0) m_duty = m_pend;
        m_pend = -1;
      end else if (wr) begin
        m_pend = sat;
      end
      if (wrap) m_run = 1;
      m_pulse = wrap;
      m_pwm   = m_run && (c < m_duty);
      if (CHECK_ON) begin
        if (bad)      m_err = 1;
        else if (clr) m_err = 0;
      end
      m_prev = c;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    step(0, 5, 0, 0, 0);
    step(0, 5, 1, 7, 1);
    checks++;
    if ({pwm_out, period_pulse, duty_active, step_err} !== 7'b0) begin
      errors++;
      $display("FAIL reset act=%b required=%b", {pwm_out, period_pulse, duty_active, step_err}, 7'b0);
    end
  endtask

  task automatic test_basic;
    int pulses = 0;
    int highs  = 0;
    for (int i = 0; i < 24; i++) begin
      step(1, i % 8, i == 0, 3, 0);
      pulses += period_pulse;
      if (i >= 8 && i < 16) highs += pwm_out;
      checks++;
      if ({pwm_out, period_pulse, duty_active, step_err} !== {m_pwm, m_pulse, 4'(m_duty), m_err}) begin
        errors++;
        $display("FAIL basic i=%0d act=%b required=%b", i,
                 {pwm_out, period_pulse, duty_active, step_err}, {m_pwm, m_pulse, 4'(m_duty), m_err});
      end
    end
    checks++;
    if (pulses !== 2 || highs !== 3 || duty_active !== 4'd3) begin
      errors++;
      $display("FAIL basic_summary pulses=%0d highs=%0d duty=%0d required 2 3 3", pulses, highs, duty_active);
    end
  endtask

  task automatic test_duty_extremes;
    int req[3] = '{0, 8, 12};
    int exp_high[3] = '{0, 8, 8};
    for (int k = 0; k < 3; k++) begin
      int highs = 0;
      for (int i = 0; i < 16; i++) begin
        step(1, i % 8, i == 2, req[k], 0);
        if (i >= 8) highs += pwm_out;
        checks++;
        if ({pwm_out, period_pulse, duty_active} !== {m_pwm, m_pulse, 4'(m_duty)}) begin
          errors++;
          $display("FAIL extremes duty_in=%0d i=%0d act=%b required=%b", req[k], i,
                   {pwm_out, period_pulse, duty_active}, {m_pwm, m_pulse, 4'(m_duty)});
        end
      end
      checks++;
      if (highs !== exp_high[k] || duty_active !== 4'(exp_high[k])) begin
        errors++;
        $display("FAIL extremes_period duty_in=%0d highs=%0d duty=%0d required %0d", req[k], highs, duty_active, exp_high[k]);
      end
    end
  endtask

  task automatic test_double_buffer;
    int highs = 0;
    for (int i = 0; i < 8; i++) step(1, i, i == 0, 3, 0);
    // Write 5 mid-period: current period stays at duty 3.
    for (int i = 0; i < 8; i++) begin
      step(1, i, i == 4, 5, 0);
      highs += pwm_out;
    end
    checks++;
    if (highs !== 3 || duty_active !== 4'd3) begin
      errors++;
      $display("FAIL dbuf_hold highs=%0d duty=%0d required 3 3", highs, duty_active);
    end
    highs = 0;
    for (int i = 0; i < 8; i++) begin
      step(1, i, 0, 0, 0);
      highs += pwm_out;
    end
    checks++;
    if (highs !== 5 || duty_active !== 4'd5) begin
      errors++;
      $display("FAIL dbuf_apply highs=%0d duty=%0d required 5 5", highs, duty_active);
    end
    // Write 6 on the wrap cycle: takes effect for that period.
    highs = 0;
    for (int i = 0; i < 8; i++) begin
      step(1, i, i == 0, 6, 0);
      highs += pwm_out;
    end
    checks++;
    if (highs !== 6 || duty_active !== 4'd6 || duty_active !== 4'(m_duty)) begin
      errors++;
      $display("FAIL dbuf_bypass highs=%0d duty=%0d required 6 6", highs, duty_active);
    end
  endtask

  task automatic test_stall_jump;
    bit pwm0;
    step(1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    step(1, 2, 0, 0, 0);
    pwm0 = pwm_out;
    for (int i = 0; i < 4; i++) begin
      step(1, 2, 0, 0, 0);
      checks++;
      if (pwm_out !== pwm0 || step_err !== 1'b0 || period_pulse !== 1'b0) begin
        errors++;
        $display("FAIL stall i=%0d pwm=%b err=%b pulse=%b required %b 0 0", i, pwm_out, step_err, period_pulse, pwm0);
      end
    end
    step(1, 5, 0, 0, 0);
    step(1, 6, 0, 0, 0);
    checks++;
    if (step_err !== CHECK_ON || step_err !== m_err) begin
      errors++;
      $display("FAIL jump_err act=%b required=%b", step_err, CHECK_ON);
    end
    step(1, 7, 0, 0, 1);
    checks++;
    if (step_err !== 1'b0) begin
      errors++;
      $display("FAIL err_clr act=%b required=0", step_err);
    end
    // Illegal step together with err_clr: set wins.
    step(1, 3, 0, 0, 1);
    checks++;
    if (step_err !== CHECK_ON) begin
      errors++;
      $display("FAIL set_over_clr act=%b required=%b", step_err, CHECK_ON);
    end
    step(1, 4, 0, 0, 1);
  endtask

  task automatic test_reset_midrun;
    int highs = 0;
    int pulses = 0;
    for (int i = 0; i < 8; i++) step(1, i, i == 1, 7, 0);
    step(1, 0, 0, 0, 0);
    step(1, 5, 1, 4, 0);   // pending write that reset must discard
    step(0, 5, 0, 0, 0);
    checks++;
    if ({pwm_out, period_pulse, duty_active, step_err} !== 7'b0) begin
      errors++;
      $display("FAIL midrun_reset act=%b required=0", {pwm_out, period_pulse, duty_active, step_err});
    end
    for (int i = 6; i < 24; i++) begin
      step(1, i % 8, 0, 0, 0);
      highs  += pwm_out;
      pulses += period_pulse;
    end
    checks++;
    if (highs !== 0 || pulses !== 2 || duty_active !== 4'd0) begin
      errors++;
      $display("FAIL midrun_after highs=%0d pulses=%0d duty=%0d required 0 2 0", highs, pulses, duty_active);
    end
  endtask

  task automatic test_random;
    int c = 0;
    for (int i = 0; i < 800; i++) begin
      int p = $urandom_range(0, 99);
      bit r = ($urandom_range(0, 99) != 0);
      if (p < 80)      c = (c + 1) % 8;
      else if (p < 92) c = c;
      else             c = $urandom_range(0, 7);
      step(r, c, $urandom_range(0, 9) == 0, $urandom_range(0, 15), $urandom_range(0, 19) == 0);
      checks++;
      if ({pwm_out, period_pulse, duty_active, step_err} !== {m_pwm, m_pulse, 4'(m_duty), m_err}) begin
        errors++;
        $display("FAIL random i=%0d count=%0d act=%b required=%b", i, c,
                 {pwm_out, period_pulse, duty_active, step_err}, {m_pwm, m_pulse, 4'(m_duty), m_err});
      end
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_duty_extremes;
    test_double_buffer;
    test_stall_jump;
    test_reset_midrun;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
